// File: rtl/ri5cy_mem_arb_pkg.sv
// Purpose : shared constants, request record and helpers for the RI5CY memory arbiter.
// Latency : n/a (declarations only).
// Backpres: n/a.
// Contents: MAX_REQ / MEM_RD_LATENCY limits, clog2_min1() index-width helper, and
//           mem_req_t, the per-port request record muxed onto the memory port.
//           mem_req_t is sized for the widest supported bus (64-bit address and data).
//           Narrower instances fill the low bits and leave the rest zero.
package ri5cy_mem_arb_pkg;

  localparam int MAX_REQ        = 8;
  localparam int MEM_RD_LATENCY = 1;

  localparam int MEM_MAX_AW = 64;
  localparam int MEM_MAX_DW = 64;
  localparam int MEM_MAX_BW = MEM_MAX_DW / 8;

  // Index width for n entries, never below 1 so a 1-bit pointer is always legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  typedef struct packed {
    logic                  we;
    logic [MEM_MAX_BW-1:0] be;
    logic [MEM_MAX_AW-1:0] addr;
    logic [MEM_MAX_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/ri5cy_mem_arbiter_rr_arbiter.sv
// Purpose : combinational round-robin picker; first set req bit at or after ptr, wrapping.
// Latency : 0 cycles (purely combinational).
// Backpres: none; the caller owns the pointer and decides when it advances.
// Ports   : req [N]   request vector
//           ptr [IW]  highest-priority index this cycle (must be < N)
//           gnt [N]   one-hot winner, all zero when req is zero
//           idx [IW]  winner index, zero when there is no winner
module rr_arbiter
  import ri5cy_mem_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk N candidates starting at ptr. The extra sum bit keeps ptr+k exact
  // before the modulo-N fold, which matters when N is not a power of two.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ri5cy_mem_arbiter.sv
// Purpose : round-robin share of one single-port RI5CY-style SRAM between NUM_REQ requesters.
// Latency : req->gnt 0 cycles, gnt->rvalid 1 cycle; back-to-back grants give full throughput.
// Backpres: ungranted requesters see gnt_o=0 and must hold their request; no state is kept for them.
// Ports   : clk, rstn (synchronous, active-low)
//           req_i/we_i [NUM_REQ], be_i/addr_i/wdata_i packed per requester (requester i at slice i)
//           gnt_o [NUM_REQ] one-hot same cycle, rvalid_o [NUM_REQ] one-hot next cycle,
//           rdata_o broadcast straight from mem_rdata_i
//           mem_req_o/we/be/addr/wdata to the SRAM, mem_rdata_i valid the cycle after mem_req_o
//           lock_i [NUM_REQ] only when MEM_ARB_LOCK_EN is defined
// Config  : `define MEM_ARB_LOCK_EN adds bus locking. A requester granted with lock_i set
//           keeps exclusive ownership until it drops the lock.
module ri5cy_mem_arbiter
  import ri5cy_mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]              lock_i,
`endif
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [DATA_WIDTH/8-1:0]         mem_be_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0]           mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]           mem_rdata_i
);

  localparam int IDX_W = clog2_min1(NUM_REQ);
  localparam int BE_W  = DATA_WIDTH / 8;

  mem_req_t           port_req [NUM_REQ];
  mem_req_t           sel_req;
  logic               unused_sel_bits;

  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               gnt_any;
  logic               lock_hold;

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

  // ------------------------------------------------------------------
  // Request qualification. Reset forces every grant low. While a lock
  // is held only the owner competes.
  // ------------------------------------------------------------------
`ifdef MEM_ARB_LOCK_EN
  logic               lock_vld_q, lock_vld_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

  assign lock_hold = lock_vld_q;

  always_comb begin
    req_eff = '0;
    if (rstn) begin
      if (lock_vld_q) req_eff = req_i & (NUM_REQ'(1) << lock_idx_q);
      else            req_eff = req_i;
    end
  end

  // Lock is taken by a granted, locking transfer. It is released by the owner's
  // next unlocked transfer, or by the owner going idle with the lock dropped.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_idx_d = lock_idx_q;
    if (lock_vld_q) begin
      if (!lock_i[lock_idx_q] && (gnt_any || !req_i[lock_idx_q])) lock_vld_d = 1'b0;
    end else if (gnt_any && lock_i[arb_idx]) begin
      lock_vld_d = 1'b1;
      lock_idx_d = arb_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  assign lock_hold = 1'b0;
  assign req_eff   = rstn ? req_i : '0;
`endif

  // ------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------
  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_arbiter (
    .req (req_eff),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign gnt_any   = |arb_gnt;
  assign gnt_o     = arb_gnt;
  assign mem_req_o = gnt_any;

  // ------------------------------------------------------------------
  // Request mux: unpack each port into a full-width record, then select
  // the winner. With no grant the memory sees all-zero data fields.
  // ------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      port_req[i]                        = '0;
      port_req[i].we                     = we_i[i];
      port_req[i].be[BE_W-1:0]           = be_i[i*BE_W +: BE_W];
      port_req[i].addr[ADDR_WIDTH-1:0]   = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      port_req[i].wdata[DATA_WIDTH-1:0]  = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    sel_req = '0;
    if (gnt_any) sel_req = port_req[arb_idx];
  end

  assign mem_we_o    = sel_req.we;
  assign mem_be_o    = sel_req.be[BE_W-1:0];
  assign mem_addr_o  = sel_req.addr[ADDR_WIDTH-1:0];
  assign mem_wdata_o = sel_req.wdata[DATA_WIDTH-1:0];

  // The padding above the configured widths is always zero.
  assign unused_sel_bits = ^sel_req;

  // ------------------------------------------------------------------
  // Pointer and response. The pointer moves past the winner. A single
  // requester therefore rotates the pointer too, which costs nothing.
  // Under lock it stays put, so the next requester in line goes first
  // once the lock drops.
  // ------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any && !lock_hold) begin
      if (arb_idx == IDX_W'(NUM_REQ - 1)) rr_ptr_d = '0;
      else                                rr_ptr_d = arb_idx + 1'b1;
    end
  end

  // Memory read latency is one cycle, so the response follows the grant
  // by one flop. Writes get an rvalid too so requesters can count completions.
  assign rvalid_d = arb_gnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      rvalid_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = mem_rdata_i;

endmodule

// File: doc/ri5cy_mem_arbiter.md
Name: ri5cy_mem_arbiter

Overview:
- Shares one single-port RI5CY-style memory (req/we/be/addr/wdata/rdata, fixed 1-cycle read latency) between NUM_REQ requesters, e.g. core data port, AHB bridge and debug.
- Round-robin grant in the request cycle, then a registered rvalid one cycle later, routed to the granted requester.
- Sits between the requester ports (AHB-to-RI5CY bridges, core LSU) and the on-chip SRAM.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits.

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous reset, active-low
- req_i  input  NUM_REQ  per-requester request
- we_i  input  NUM_REQ  per-requester write enable
- be_i  input  NUM_REQ*DATA_WIDTH/8  packed byte enables, requester i at slice i
- addr_i  input  NUM_REQ*ADDR_WIDTH  packed addresses
- wdata_i  input  NUM_REQ*DATA_WIDTH  packed write data
- gnt_o  output  NUM_REQ  one-hot grant, same cycle as req
- rvalid_o  output  NUM_REQ  one-hot response valid, one cycle after gnt
- rdata_o  output  DATA_WIDTH  read data, broadcast to all requesters
- mem_req_o  output  1  memory request
- mem_we_o  output  1  memory write enable
- mem_be_o  output  DATA_WIDTH/8  memory byte enables
- mem_addr_o  output  ADDR_WIDTH  memory address
- mem_wdata_o  output  DATA_WIDTH  memory write data
- mem_rdata_i  input  DATA_WIDTH  memory read data, valid the cycle after mem_req_o

Behaviour:
- Reset (rstn=0 at posedge clk):
  - rr_ptr is set to 0 and rvalid_o is set to 0.
  - While rstn=0, gnt_o and mem_req_o are forced to 0.
- Grant selection (combinational):
  - Search req_i starting at index rr_ptr, incrementing and wrapping at NUM_REQ-1 -> 0.
  - The first set bit wins. gnt_o is one-hot on the winner; mem_req_o = |req_i.
  - mem_we/be/addr/wdata are muxed from the winner's slices.
  - With no request, gnt_o = 0, mem_req_o = 0, and the mem_* data outputs are 0.
- Pointer update: on a posedge with a grant to index w, rr_ptr <= (w+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Response:
  - rvalid_o <= gnt_o (registered), issued for reads and writes alike.
  - rdata_o = mem_rdata_i unregistered; it is meaningful only when some rvalid_o bit is set.
- Latency: request to gnt is 0 cycles; gnt to rvalid is 1 cycle.
  - Back-to-back grants every cycle are allowed, giving full throughput.
- Requester rules:
  - A requester holds req/we/be/addr/wdata stable until gnt.
  - It may drop req without a grant; the arbiter keeps no state for ungranted requests.
- Starvation bound: a continuously requesting port is granted within NUM_REQ cycles.
- Single requester: it is granted every cycle it requests. rr_ptr still advances to w+1, which is harmless.
- Simultaneous response and new grant: rvalid_o for the previous grant and gnt_o for a new grant, possibly the same requester, coexist in one cycle.
- Reset mid-operation:
  - An outstanding rvalid is dropped and is not delivered after reset.
  - Requesters must discard in-flight transactions when reset.
- be_i is passed through unmodified; the arbiter performs no alignment.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- With the macro defined:
  - Adds port lock_i (input, NUM_REQ) and registers lock_vld and lock_idx.
  - When requester w is granted with lock_i[w]=1, then lock_vld<=1 and lock_idx<=w.
  - While lock_vld=1, only lock_idx may be granted; all others see gnt=0, and rr_ptr holds.
  - lock_vld clears on either of two events:
    - a granted transaction from lock_idx with lock_i=0;
    - a cycle where req_i[lock_idx]=0 and lock_i[lock_idx]=0.
  - Reset clears lock_vld.
- Without the macro: no lock_i port, pure round-robin.

Decomposition:
- Package ri5cy_mem_arb_pkg holds:
  - localparams MAX_REQ=8 and MEM_RD_LATENCY=1;
  - function clog2_min1;
  - typedef mem_req_t (we, be, addr, wdata) for the per-port muxing.
- Sub-module rr_arbiter(N): combinational inputs req and ptr, outputs one-hot gnt and index. Instantiated once; it is also reusable by other shared-resource blocks.

Test Plan:
1. Reset with req_i=2'b11 held: while rstn=0, gnt_o=0, mem_req_o=0, rvalid_o=0. In the first cycle after release, gnt_o=2'b01 (rr_ptr=0).
2. Both ports request continuously:
   - port0 reads 0x100 and port1 reads 0x200; memory returns addr+1.
   - Expect gnt alternating 01,10,01,…
   - rvalid one cycle later on the same port, with rdata 0x101 and 0x201 respectively.
3. Single port1 write: we=1, be=4'b0011, addr=0x40, wdata=0xDEADBEEF.
   - Same cycle: mem_req_o=1, mem_we_o=1, mem_be_o=4'b0011, mem_addr_o=0x40, mem_wdata_o=0xDEADBEEF, gnt_o=2'b10.
   - Next cycle: rvalid_o=2'b10.
4. NUM_REQ=3, all request for 9 cycles: each port is granted exactly 3 times, in order 0,1,2,0,1,2,…, with no gaps.
5. Port0 requests alone for 4 cycles, then port1 joins: grants are 0,0,0,0, then 1 in the next cycle (rr_ptr=1), then 0.
6. (MEM_ARB_LOCK_EN) Port0 is granted with lock_i[0]=1 while port1 requests: port1 gets no gnt for 3 cycles. Port0 then issues a transaction with lock_i[0]=0, and port1 is granted in the following cycle.
